// File: rtl/ppm_frame_ctrl.sv
// rtl/ppm_frame_ctrl.sv - PPM receive frame controller with abort-rewind byte FIFO
module ppm_frame_ctrl #(
  parameter int DEPTH   = 16,
  parameter int MAX_LEN = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Dout,
  input  logic       D_en,
  input  logic       F_en,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_done,
  output logic [7:0] frame_len,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, RECV, ABORT} state_t;

  state_t          state_q, state_d;
  logic            f_en_d_q;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, sof_ptr_q, sof_ptr_d;
  logic [7:0]      pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic [7:0]      byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            rd_in_frame_q, rd_in_frame_d;
  logic            frame_done_q, frame_done_d, frame_err_q, frame_err_d;
  logic [7:0]      frame_len_q, frame_len_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [8:0]      mem_q [DEPTH];

  logic            rise, fall, empty, pop, dcap, in_frame_now;
  logic            ovf_err, len_err, tmo_err, empty_err, wr_en0, wr_en1;
  logic [1:0]      npush;
  logic [PW-1:0]   count, free;
  logic [8:0]      head, e0, e1;
  logic [AW-1:0]   wa0, wa1;

  assign rise    = F_en & ~f_en_d_q;
  assign fall    = ~F_en & f_en_d_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign m_valid = ~empty;
  assign pop     = m_valid & m_ready;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign m_data  = m_valid ? head[7:0] : 8'd0;
  assign m_last  = m_valid & head[8];
  assign count   = wr_ptr_q - rd_ptr_q;
  assign free    = PW'(DEPTH) - count + PW'(pop);
  assign dcap    = (state_q == RECV) & D_en;

  // Byte and EOF together with a held byte means two entries land in one cycle.
  assign npush = {1'b0, pend_vld_q & (dcap | fall)} + {1'b0, fall & dcap};
  assign e0    = {fall & ~(pend_vld_q & dcap), pend_vld_q ? pend_q : Dout};
  assign e1    = {1'b1, Dout};
  assign wa0   = wr_ptr_q[AW-1:0];
  assign wa1   = wa0 + AW'(1);

  assign ovf_err   = (PW'(npush) > free);
  assign len_err   = dcap & (byte_cnt_q == 8'(MAX_LEN));
  assign tmo_err   = ~dcap & ~fall & (tmo_cnt_q == TW'(TIMEOUT - 1));
  assign empty_err = fall & ~dcap & ~pend_vld_q;
  assign in_frame_now = rd_in_frame_q | (pop & (rd_ptr_q == sof_ptr_q));

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    sof_ptr_d     = sof_ptr_q;
    pend_d        = pend_q;
    pend_vld_d    = pend_vld_q;
    byte_cnt_d    = byte_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    rd_in_frame_d = rd_in_frame_q;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    frame_len_d   = frame_len_q;
    err_code_d    = err_code_q;
    wr_en0        = 1'b0;
    wr_en1        = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d       = RECV;
          sof_ptr_d     = wr_ptr_q;
          byte_cnt_d    = 8'd0;
          tmo_cnt_d     = '0;
          pend_vld_d    = 1'b0;
          rd_in_frame_d = 1'b0;
        end
      end
      RECV: begin
        rd_in_frame_d = in_frame_now;
        if (ovf_err | len_err | tmo_err | empty_err) begin
          frame_err_d = 1'b1;
          err_code_d  = ovf_err ? 2'd1 : len_err ? 2'd2 : tmo_err ? 2'd3 : 2'd0;
          // Once the reader has eaten into this frame, rd_ptr is the oldest byte left.
          wr_ptr_d    = in_frame_now ? rd_ptr_d : sof_ptr_q;
          pend_vld_d  = 1'b0;
          state_d     = empty_err ? IDLE : ABORT;
        end else begin
          wr_en0   = (npush != 2'd0);
          wr_en1   = (npush == 2'd2);
          wr_ptr_d = wr_ptr_q + PW'(npush);
          if (dcap) begin
            pend_d     = Dout;
            pend_vld_d = 1'b1;
            byte_cnt_d = byte_cnt_q + 8'd1;
            tmo_cnt_d  = '0;
          end else begin
            tmo_cnt_d  = tmo_cnt_q + TW'(1);
          end
          if (fall) begin
            frame_done_d = 1'b1;
            frame_len_d  = byte_cnt_q + {7'd0, dcap};
            pend_vld_d   = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      ABORT: begin
        if (!F_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en0) mem_q[wa0] <= e0;
    if (wr_en1) mem_q[wa1] <= e1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= IDLE;
      f_en_d_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sof_ptr_q     <= '0;
      pend_q        <= 8'd0;
      pend_vld_q    <= 1'b0;
      byte_cnt_q    <= 8'd0;
      tmo_cnt_q     <= '0;
      rd_in_frame_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_len_q   <= 8'd0;
      err_code_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      f_en_d_q      <= F_en;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      sof_ptr_q     <= sof_ptr_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      byte_cnt_q    <= byte_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      rd_in_frame_q <= rd_in_frame_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      frame_len_q   <= frame_len_d;
      err_code_q    <= err_code_d;
    end
  end

  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ppm_frame_ctrl.sv
// tb/tb_ppm_frame_ctrl.sv - directed self-checking bench for ppm_frame_ctrl
module tb_ppm_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] Dout;
  logic       D_en, F_en, m_ready;
  logic [7:0] m_data, frame_len;
  logic       m_valid, m_last, frame_done, frame_err, busy;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  ppm_frame_ctrl #(.DEPTH(4), .MAX_LEN(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .Dout(Dout), .D_en(D_en), .F_en(F_en),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .frame_done(frame_done), .frame_len(frame_len), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] out_q[$];
  int len_q[$];
  int err_q[$];

  always @(negedge clk) begin
    if (m_valid && m_ready) out_q.push_back({m_last, m_data});
    if (frame_done) len_q.push_back(int'(frame_len));
    if (frame_err) err_q.push_back(int'(err_code));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs;
    out_q.delete();
    len_q.delete();
    err_q.delete();
  endtask

  task automatic put(input logic [7:0] b);
    Dout = b;
    D_en = 1'b1;
    tick();
    D_en = 1'b0;
  endtask

  task automatic start_frame;
    F_en = 1'b1;
    tick();
  endtask

  task automatic end_frame;
    F_en = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset;
    n_checks++;
    if ({m_valid, m_data, m_last, frame_done, frame_len, frame_err, err_code, busy} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {m_valid, m_data, m_last, frame_done, frame_len, frame_err, err_code, busy});
    end
  endtask

  task automatic test_single_frame;
    logic [8:0] exp[$];
    exp = '{9'h011, 9'h022, 9'h133};
    clear_logs();
    m_ready = 1'b1;
    start_frame();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b required 1", busy); end
    put(8'h11); put(8'h22); put(8'h33);
    end_frame();
    n_checks++;
    if (out_q.size() != 3) begin n_fail++; $display("FAIL single_count: got %0d required 3", out_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (((i < out_q.size()) ? out_q[i] : 9'h1ff) !== exp[i]) begin
        n_fail++;
        $display("FAIL single_byte%0d: got %h required %h", i, (i < out_q.size()) ? out_q[i] : 9'h1ff, exp[i]);
      end
    end
    n_checks++;
    if (len_q.size() != 1 || len_q[0] != 3) begin
      n_fail++; $display("FAIL single_done: got %0d pulses required one with len 3", len_q.size());
    end
  endtask

  task automatic test_empty;
    clear_logs();
    m_ready = 1'b1;
    start_frame();
    repeat (4) tick();
    F_en = 1'b0;
    tick();
    n_checks++;
    if (frame_err !== 1'b1 || err_code !== 2'd0) begin
      n_fail++; $display("FAIL empty_err: got err=%b code=%0d required err=1 code=0", frame_err, err_code);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_idle: got busy=%b required 0", busy); end
    repeat (3) tick();
    n_checks++;
    if (out_q.size() != 0 || len_q.size() != 0 || err_q.size() != 1) begin
      n_fail++; $display("FAIL empty_logs: got out=%0d done=%0d err=%0d required 0/0/1", out_q.size(), len_q.size(), err_q.size());
    end
  endtask

  task automatic test_length;
    clear_logs();
    m_ready = 1'b0;
    start_frame();
    put(8'hA1); put(8'hA2); put(8'hA3); put(8'hA4);
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL length_early: got err=%b required 0", frame_err); end
    put(8'hA5);
    n_checks++;
    if (frame_err !== 1'b1 || err_code !== 2'd2) begin
      n_fail++; $display("FAIL length_err: got err=%b code=%0d required err=1 code=2", frame_err, err_code);
    end
    n_checks++;
    if (m_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL length_rewind: got valid=%b busy=%b required valid=0 busy=1", m_valid, busy);
    end
    F_en = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL length_exit: got busy=%b required 0", busy); end
    clear_logs();
    m_ready = 1'b1;
    start_frame();
    put(8'hB1); put(8'hB2);
    end_frame();
    n_checks++;
    if (out_q.size() != 2 || out_q[0] !== 9'h0B1 || out_q[1] !== 9'h1B2) begin
      n_fail++; $display("FAIL length_next_frame: got %0d bytes first=%h required 0b1,1b2", out_q.size(), (out_q.size() > 0) ? out_q[0] : 9'h1ff);
    end
    n_checks++;
    if (len_q.size() != 1 || len_q[0] != 2) begin
      n_fail++; $display("FAIL length_next_done: got %0d pulses required one with len 2", len_q.size());
    end
  endtask

  task automatic test_overflow;
    clear_logs();
    m_ready = 1'b0;
    start_frame();
    put(8'hC1); put(8'hC2);
    F_en = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({m_valid, m_last, m_data} !== 10'h2C1) begin
        n_fail++; $display("FAIL ovf_hold%0d: got %h required 2c1", i, {m_valid, m_last, m_data});
      end
      tick();
    end
    start_frame();
    put(8'hD1); put(8'hD2); put(8'hD3); put(8'hD4);
    n_checks++;
    if (frame_err !== 1'b1 || err_code !== 2'd1) begin
      n_fail++; $display("FAIL ovf_err: got err=%b code=%0d required err=1 code=1", frame_err, err_code);
    end
    put(8'hD5); put(8'hD6);
    F_en = 1'b0;
    tick(); tick();
    m_ready = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (out_q.size() != 2 || out_q[0] !== 9'h0C1 || out_q[1] !== 9'h1C2) begin
      n_fail++; $display("FAIL ovf_kept: got %0d bytes first=%h required 0c1,1c2", out_q.size(), (out_q.size() > 0) ? out_q[0] : 9'h1ff);
    end
    n_checks++;
    if (err_q.size() != 1 || len_q.size() != 1 || len_q[0] != 2) begin
      n_fail++; $display("FAIL ovf_pulses: got err=%0d done=%0d required 1/1", err_q.size(), len_q.size());
    end
  endtask

  task automatic test_timeout;
    int hit;
    hit = 0;
    clear_logs();
    m_ready = 1'b1;
    start_frame();
    put(8'hE1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (frame_err && hit == 0) hit = k;
    end
    n_checks++;
    if (hit != 16) begin n_fail++; $display("FAIL timeout_cycle: got %0d required 16", hit); end
    n_checks++;
    if (err_q.size() != 1 || err_q[0] != 3) begin
      n_fail++; $display("FAIL timeout_code: got %0d pulses required one with code 3", err_q.size());
    end
    n_checks++;
    if (busy !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_abort: got busy=%b valid=%b required busy=1 valid=0", busy, m_valid);
    end
    F_en = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_exit: got busy=%b required 0", busy); end
  endtask

  task automatic test_rewind_after_pop;
    clear_logs();
    m_ready = 1'b1;
    start_frame();
    put(8'h71); put(8'h72); put(8'h73); put(8'h74); put(8'h75);
    n_checks++;
    if (frame_err !== 1'b1 || err_code !== 2'd2 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL rewind_state: got err=%b code=%0d valid=%b required 1/2/0", frame_err, err_code, m_valid);
    end
    F_en = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (out_q.size() != 3 || out_q[0] !== 9'h071 || out_q[2] !== 9'h073) begin
      n_fail++; $display("FAIL rewind_stream: got %0d bytes required 071,072,073", out_q.size());
    end
  endtask

  task automatic test_coincident_eof;
    clear_logs();
    m_ready = 1'b1;
    start_frame();
    put(8'hF1);
    Dout = 8'hF2; D_en = 1'b1; F_en = 1'b0;
    tick();
    D_en = 1'b0;
    repeat (3) tick();
    start_frame();
    Dout = 8'hF3; D_en = 1'b1; F_en = 1'b0;
    tick();
    D_en = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (out_q.size() != 3 || out_q[0] !== 9'h0F1 || out_q[1] !== 9'h1F2 || out_q[2] !== 9'h1F3) begin
      n_fail++; $display("FAIL coinc_stream: got %0d bytes last=%h required 0f1,1f2,1f3", out_q.size(), (out_q.size() > 0) ? out_q[out_q.size()-1] : 9'h1ff);
    end
    n_checks++;
    if (len_q.size() != 2 || len_q[0] != 2 || len_q[1] != 1) begin
      n_fail++; $display("FAIL coinc_len: got %0d pulses required lens 2,1", len_q.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    clear_logs();
    m_ready = 1'b0;
    start_frame();
    put(8'h51); put(8'h52); put(8'h53);
    n_checks++;
    if (m_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got valid=%b required 1", m_valid); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({m_valid, m_data, m_last, frame_done, frame_err, busy} !== 13'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got %h required 0", {m_valid, m_data, m_last, frame_done, frame_err, busy});
    end
    F_en = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (len_q.size() != 0 || err_q.size() != 0 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_after: got done=%0d err=%0d valid=%b required 0/0/0", len_q.size(), err_q.size(), m_valid);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    Dout = 8'd0; D_en = 1'b0; F_en = 1'b0; m_ready = 1'b0;
    tick(); tick();
    test_reset();
    rst_n = 1'b0;
    tick();
    test_single_frame();
    test_empty();
    test_length();
    test_overflow();
    test_timeout();
    test_rewind_after_pop();
    test_coincident_eof();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ppm_frame_ctrl.md
Name: ppm_frame_ctrl

Overview:
- Frame-level receive controller behind the PPM decoder.
- Consumes the decoder's byte stream (Dout/D_en) and frame envelope (F_en), and buffers bytes in a FIFO with a per-entry last flag.
- Enforces length and inter-byte timeout limits and presents frames downstream on a valid/ready stream.
- On any error, discards only the aborted frame; completed frames still in the FIFO are kept.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, ≥4.
- MAX_LEN, 64, maximum bytes per frame (1..255).
- TIMEOUT, 4096, max clk cycles allowed in RECV since SOF or the last D_en.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-high.
- Dout  in  8  decoded byte; valid when D_en=1.
- D_en  in  1  one-cycle byte strobe.
- F_en  in  1  frame envelope; high from SOF to EOF.
- m_data  out  8  FIFO head byte.
- m_valid  out  1  FIFO non-empty.
- m_last  out  1  head byte is the final byte of a good frame.
- m_ready  in  1  downstream accept.
- frame_done  out  1  one-cycle pulse: good frame fully enqueued.
- frame_len  out  8  byte count of the frame; valid with frame_done.
- frame_err  out  1  one-cycle pulse: frame aborted.
- err_code  out  2  abort cause, valid with frame_err: 0 EMPTY, 1 OVERFLOW, 2 LENGTH, 3 TIMEOUT.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: FSM=IDLE. All pointers, byte_cnt, tmo_cnt, pend_vld, f_en_d = 0. All outputs 0.
- Edge detect: f_en_d registers F_en. rise = F_en & ~f_en_d; fall = ~F_en & f_en_d.
- States: IDLE, RECV, ABORT.
- IDLE, on rise -> RECV:
  - sof_ptr <= wr_ptr; byte_cnt <= 0; tmo_cnt <= 0; pend_vld <= 0.
  - D_en in IDLE or ABORT is ignored.
- RECV, on D_en:
  - If pend_vld, push the pending byte with last=0.
  - pend <= Dout; pend_vld <= 1; byte_cnt++; tmo_cnt <= 0.
  - The one-byte hold-back exists so that last can be attached at EOF.
- RECV, on fall:
  - byte_cnt==0 -> frame_err, code EMPTY -> IDLE.
  - Otherwise push pend with last=1; frame_done=1 next cycle with frame_len=byte_cnt -> IDLE.
- D_en and fall in the same cycle: the byte is captured first and becomes the last byte; frame_len includes it.
- Rise in the same cycle the FSM returns to IDLE: not a new frame. f_en_d forces a new rise first.
- Error checks in RECV, priority OVERFLOW > LENGTH > TIMEOUT:
  - OVERFLOW: a push is required while the FIFO is full and no pop happens in the same cycle. Push with a simultaneous pop on a full FIFO is legal.
  - LENGTH: D_en arrives with byte_cnt==MAX_LEN.
  - TIMEOUT: tmo_cnt reaches TIMEOUT-1 with no D_en.
- On any error:
  - Rewind wr_ptr to sof_ptr. If the reader has already popped the entry at sof_ptr during this frame (flag rd_in_frame), rewind to rd_ptr instead.
  - Clear pend_vld; pulse frame_err with err_code; -> ABORT.
- ABORT: wait for F_en==0 -> IDLE. Bytes are discarded.
- FIFO:
  - First-word fall-through; a pushed byte appears on m_valid the next cycle.
  - Pop when m_valid & m_ready.
  - Pointers are log2(DEPTH)+1 bits; full/empty use the MSB-differ compare; wrap-around is natural.
- Latency: byte on D_en at cycle N enters the FIFO at the next D_en or EOF, and is visible on m_data one cycle after that push.
- m_data and m_last are stable while m_valid=1 and m_ready=0.
- A reset mid-frame empties the FIFO and drops all frames; no pulses are generated.

Test Plan:
- Single frame 0x11,0x22,0x33, m_ready=1 -> stream 11,22,33 with m_last only on 0x33; frame_done once, frame_len=3.
- F_en high for 100 cycles with no D_en -> frame_err, err_code=0; m_valid stays 0.
- MAX_LEN=4, 5 bytes sent -> frame_err, code 2 on the 5th D_en; FIFO holds no bytes of that frame. A following 2-byte frame is delivered intact.
- DEPTH=4, m_ready=0: frame A of 2 bytes completes, then frame B sends 6 bytes -> OVERFLOW (code 1). Only A's 2 bytes remain, last on byte 2.
- TIMEOUT=16, one byte then 20 idle cycles with F_en high -> frame_err, code 3 at cycle 16 after the byte. ABORT until F_en falls; busy=1 throughout.
- Last D_en coincident with F_en fall -> that byte carries m_last and is counted in frame_len. Assert reset mid-frame -> all outputs 0 immediately.
